// File: rtl/mem_arbiter.sv
// Byte-serial memory bus sequencer shared by instruction fetch and the load/store buffer.
// Each access is split into byte beats; read bytes are assembled little-endian.
module mem_arbiter #(
    parameter int unsigned IF_BYTES = 4,
    parameter logic [1:0]  IO_SEL   = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e      state_q;
    logic        last_data_q;
    logic        src_data_q;
    logic        we_q;
    logic [2:0]  n_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [2:0]  beat_q;
    logic        pend_q;
    logic [1:0]  pidx_q;
    logic [31:0] asm_q;
    logic        if_done_q;
    logic [31:0] if_data_q;
    logic        d_done_q;
    logic [31:0] d_rdata_q;

    logic        idle;
    logic        pick_data;
    logic        grant;
    logic        active;
    logic        cur_we;
    logic [2:0]  cur_n;
    logic [31:0] cur_base;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_beat;
    logic [31:0] beat_addr;
    logic [7:0]  wbyte;
    logic        io_stall;
    logic [31:0] cap_word;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // In IDLE the winning request's operands drive the bus directly so the grant cycle is beat 0.
    always_comb begin
        idle      = (state_q == IDLE);
        pick_data = d_req && (!if_req || !last_data_q);
        grant     = idle && rdy && !flush && !if_done_q && !d_done_q && (if_req || d_req);
        active    = grant || !idle;
        cur_we    = idle ? (pick_data && d_we) : we_q;
        cur_n     = idle ? (pick_data ? size_bytes(d_size) : 3'(IF_BYTES)) : n_q;
        cur_base  = idle ? (pick_data ? d_addr : if_addr) : base_q;
        cur_wdata = idle ? d_wdata : wdata_q;
        cur_beat  = idle ? '0 : beat_q;
        beat_addr = cur_base + {29'd0, cur_beat};
        case (cur_beat[1:0])
            2'd0:    wbyte = cur_wdata[7:0];
            2'd1:    wbyte = cur_wdata[15:8];
            2'd2:    wbyte = cur_wdata[23:16];
            default: wbyte = cur_wdata[31:24];
        endcase
        io_stall = cur_we && (beat_addr[17:16] == IO_SEL) && io_buffer_full;
        mem_a    = active ? beat_addr : '0;
        mem_dout = (active && cur_we) ? wbyte : '0;
        mem_wr   = active && rdy && cur_we && !io_stall;

        cap_word = asm_q;
        case (pidx_q)
            2'd0:    cap_word[7:0]   = mem_din;
            2'd1:    cap_word[15:8]  = mem_din;
            2'd2:    cap_word[23:16] = mem_din;
            default: cap_word[31:24] = mem_din;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            src_data_q  <= 1'b0;
            we_q        <= 1'b0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            beat_q      <= '0;
            pend_q      <= 1'b0;
            pidx_q      <= '0;
            asm_q       <= '0;
            if_done_q   <= 1'b0;
            if_data_q   <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
        end else if (rdy) begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        last_data_q <= pick_data;
                        src_data_q  <= pick_data;
                        we_q        <= cur_we;
                        n_q         <= cur_n;
                        base_q      <= cur_base;
                        wdata_q     <= cur_wdata;
                        asm_q       <= '0;
                        if (cur_we) begin
                            if (io_stall) begin
                                beat_q  <= '0;
                                state_q <= WRITE;
                            end else if (cur_n == 3'd1) begin
                                d_done_q <= 1'b1;
                            end else begin
                                beat_q  <= 3'd1;
                                state_q <= WRITE;
                            end
                        end else begin
                            beat_q  <= 3'd1;
                            pend_q  <= 1'b1;
                            pidx_q  <= '0;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (flush) begin
                        pend_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (pend_q) asm_q <= cap_word;
                        if (beat_q < n_q) begin
                            pend_q <= 1'b1;
                            pidx_q <= beat_q[1:0];
                            beat_q <= beat_q + 3'd1;
                        end else begin
                            pend_q  <= 1'b0;
                            state_q <= IDLE;
                            if (src_data_q) begin
                                d_done_q  <= 1'b1;
                                d_rdata_q <= cap_word;
                            end else begin
                                if_done_q <= 1'b1;
                                if_data_q <= cap_word;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        if (beat_q == n_q - 3'd1) begin
                            d_done_q <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            beat_q <= beat_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end else if (state_q == READ && pend_q) begin
            // The byte in flight lands during the pause and is lost; rewind so it is issued again.
            pend_q <= 1'b0;
            beat_q <= {1'b0, pidx_q};
        end
    end

    assign if_done = if_done_q;
    assign if_data = if_data_q;
    assign d_done  = d_done_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus multi-cycle
// sequences for arbitration, IO stall, flush, rdy pause and mid-access reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        flush;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;

    vec_t vecs [13];
    int   tie_c [4] = '{5, 11, 17, 23};
    logic tie_f [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    mem_arbiter #(.IF_BYTES(4), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .flush(flush), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: byte for the address of one cycle appears the next cycle.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[15:0]] <= mem_dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no done pulse expected one within budget", name);
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
    endtask

    task automatic no_done(input string name, input int n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            got = got | if_done | d_done;
        end
        chk(name, 32'(got), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int          nb;
        bit          seen;
        logic [31:0] wd;
        nb   = v.we ? v.lat : v.lat - 1;
        seen = 1'b0;
        @(negedge clk);
        if_req  = v.fetch;
        d_req   = !v.fetch;
        d_we    = v.we;
        d_size  = v.size;
        d_addr  = v.addr;
        if_addr = v.addr;
        d_wdata = v.wdata;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c < nb) begin
                chk({v.name, "_addr"}, mem_a, v.addr + 32'(c));
                chk({v.name, "_wr"}, 32'(mem_wr), 32'(v.we));
                if (v.we) begin
                    wd = v.wdata >> (8 * c);
                    chk({v.name, "_dout"}, 32'(mem_dout), 32'(wd[7:0]));
                end
            end
            if (if_done || d_done) begin
                seen = 1'b1;
                chk({v.name, "_lat"}, 32'(c), 32'(v.lat));
                chk({v.name, "_src"}, {30'd0, if_done, d_done}, v.fetch ? 32'd2 : 32'd1);
                if (!v.we) chk({v.name, "_data"}, v.fetch ? if_data : d_rdata, v.exp_data);
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        if (!seen) begin
            miss(v.name);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    initial begin
        int   k;
        bit   seen;
        int   wr_cnt;
        vec_t rb;

        vecs[0]  = '{"f100",   1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         32'h0000_0513, 5};
        vecs[1]  = '{"lh2002", 1'b0, 1'b0, 2'd1, 32'h0000_2002, 32'h0,         32'h0000_ABCD, 3};
        vecs[2]  = '{"lb2003", 1'b0, 1'b0, 2'd0, 32'h0000_2003, 32'h0,         32'h0000_00AB, 2};
        vecs[3]  = '{"lw2000", 1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'hABCD_2211, 5};
        vecs[4]  = '{"ls3",    1'b0, 1'b0, 2'd3, 32'h0000_2000, 32'h0,         32'hABCD_2211, 5};
        vecs[5]  = '{"sw4000", 1'b0, 1'b1, 2'd2, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,         4};
        vecs[6]  = '{"lw4000", 1'b0, 1'b0, 2'd2, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF, 5};
        vecs[7]  = '{"sh4010", 1'b0, 1'b1, 2'd1, 32'h0000_4010, 32'h1234_5678, 32'h0,         2};
        vecs[8]  = '{"lw4010", 1'b0, 1'b0, 2'd2, 32'h0000_4010, 32'h0,         32'h0000_5678, 5};
        vecs[9]  = '{"sb4021", 1'b0, 1'b1, 2'd0, 32'h0000_4021, 32'h0000_AA55, 32'h0,         1};
        vecs[10] = '{"lh4020", 1'b0, 1'b0, 2'd1, 32'h0000_4020, 32'h0,         32'h0000_5500, 3};
        vecs[11] = '{"fwrap",  1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'h0201_BC9A, 5};
        vecs[12] = '{"lb2000", 1'b0, 1'b0, 2'd0, 32'h0000_2000, 32'h0,         32'h0000_0011, 2};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = '0;
        d_addr = '0; d_wdata = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;

        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
        poke(16'h2000, 8'h11); poke(16'h2001, 8'h22); poke(16'h2002, 8'hCD); poke(16'h2003, 8'hAB);
        poke(16'hFFFE, 8'h9A); poke(16'hFFFF, 8'hBC); poke(16'h0000, 8'h01); poke(16'h0001, 8'h02);
        poke(16'h4012, 8'h00); poke(16'h4013, 8'h00); poke(16'h4020, 8'h00);
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests straight out of reset, both held: fetch, data, fetch, data.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h2000;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 0) chk("tie_first_addr", mem_a, 32'h100);
            if (c == 6) chk("tie_second_addr", mem_a, 32'h2000);
            if (if_done || d_done) begin
                chk("tie_cycle", 32'(c), 32'(tie_c[k]));
                chk("tie_src", 32'(if_done), 32'(tie_f[k]));
                chk("tie_data", if_done ? if_data : d_rdata, tie_f[k] ? 32'h513 : 32'hABCD_2211);
                k++;
                if (k == 4) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        if (k < 4) begin
            miss("tie");
            if_req = 1'b0;
            d_req  = 1'b0;
        end

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // IO-space byte store held off by a full UART buffer for three cycles.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h0003_0000; d_wdata = 32'h41;
        io_buffer_full = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3) io_buffer_full = 1'b0;
            #1;
            if (c < 3) begin
                chk("io_stall_wr", 32'(mem_wr), 32'd0);
                chk("io_stall_addr", mem_a, 32'h0003_0000);
            end
            if (c == 3) begin
                chk("io_go_wr", 32'(mem_wr), 32'd1);
                chk("io_go_dout", 32'(mem_dout), 32'h41);
            end
            if (d_done) begin
                seen = 1'b1;
                chk("io_done_cycle", 32'(c), 32'd4);
                d_req = 1'b0;
            end
        end
        if (!seen) begin miss("io_store"); d_req = 1'b0; end
        io_buffer_full = 1'b0;

        // Flush on beat 2 of a fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; if_req = 1'b0;
        #1;
        chk("ffl_beat2_addr", mem_a, 32'h102);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("ffl_idle_addr", mem_a, 32'd0);
        no_done("ffl_no_done", 8);

        // A flush cycle blocks the grant.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; flush = 1'b1;
        #1;
        chk("fgr_block_addr", mem_a, 32'd0);
        @(negedge clk);
        if_req = 1'b0; flush = 1'b0;
        #1;
        chk("fgr_idle_addr", mem_a, 32'd0);
        no_done("fgr_no_done", 8);

        // Flush during a word store does not abort it.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h5000; d_wdata = 32'h0403_0201;
        wr_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            flush = (c == 1 || c == 2);
            #1;
            if (mem_wr) wr_cnt++;
            if (d_done) begin
                seen = 1'b1;
                chk("fst_done_cycle", 32'(c), 32'd4);
                d_req = 1'b0;
            end
        end
        if (!seen) begin miss("fst"); d_req = 1'b0; end
        flush = 1'b0;
        chk("fst_beats", 32'(wr_cnt), 32'd4);
        rb = '{"rb5000", 1'b0, 1'b0, 2'd2, 32'h5000, 32'h0, 32'h0403_0201, 5};
        run_vec(rb);

        // rdy low for two cycles in the middle of a fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            rdy = !(c == 2 || c == 3);
            #1;
            if (c == 2 || c == 3) chk("rdy_rd_wr", 32'(mem_wr), 32'd0);
            if (c == 4) chk("rdy_reissue_addr", mem_a, 32'h101);
            if (c == 5) chk("rdy_b2_addr", mem_a, 32'h102);
            if (c == 6) chk("rdy_b3_addr", mem_a, 32'h103);
            if (if_done) begin
                seen = 1'b1;
                chk("rdy_rd_cycle", 32'(c), 32'd8);
                chk("rdy_rd_data", if_data, 32'h513);
                if_req = 1'b0;
            end
        end
        if (!seen) begin miss("rdy_rd"); if_req = 1'b0; end
        rdy = 1'b1;

        // rdy low during a half-word store forces mem_wr off and holds the beat.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd1; d_addr = 32'h6000; d_wdata = 32'h0000_BBAA;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            rdy = (c != 1);
            #1;
            if (c == 0) chk("rdy_st_b0_dout", 32'(mem_dout), 32'hAA);
            if (c == 1) chk("rdy_st_pause_wr", 32'(mem_wr), 32'd0);
            if (c == 2) begin
                chk("rdy_st_b1_wr", 32'(mem_wr), 32'd1);
                chk("rdy_st_b1_addr", mem_a, 32'h6001);
                chk("rdy_st_b1_dout", 32'(mem_dout), 32'hBB);
            end
            if (d_done) begin
                seen = 1'b1;
                chk("rdy_st_cycle", 32'(c), 32'd3);
                d_req = 1'b0;
            end
        end
        if (!seen) begin miss("rdy_st"); d_req = 1'b0; end
        rdy = 1'b1;
        rb = '{"rb6000", 1'b0, 1'b0, 2'd1, 32'h6000, 32'h0, 32'h0000_BBAA, 3};
        run_vec(rb);

        // Asynchronous reset in the middle of a fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1; if_req = 1'b0;
        #1;
        chk("rmid_mem_a", mem_a, 32'd0);
        chk("rmid_mem_wr", 32'(mem_wr), 32'd0);
        chk("rmid_if_data", if_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done("rmid_no_done", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
